acc_ctrl_seq: RTL



---
 rtl/acc_pkg.sv | 42 ++++
 rtl/acc_ctrl_decode.sv | 68 ++++++
 rtl/acc_ctrl_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator control sequencer: states, opcodes,
// bus/ALU encodings and the default datapath width.
package acc_pkg;

  localparam int REG_WIDTH = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JMPZ  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] BUS_MEM = 2'd0;
  localparam logic [1:0] BUS_AC  = 2'd1;
  localparam logic [1:0] BUS_IR  = 2'd2;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
      OP_JMP, OP_JMPZ, OP_HALT: op_legal = 1'b1;
      default:                  op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational strobe decoder: state + latched opcode (+ mem_ready in FETCH,
// zflag in DECODE) to datapath strobes; zero latency, no storage.
module acc_ctrl_decode
  import acc_pkg::*;
(
  input  state_t      state,
  input  logic [3:0]  opcode,
  input  logic        zflag,
  input  logic        mem_ready,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        ir_load,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  bus_sel,
  output logic [2:0]  alu_op,
  output logic        ac_write_en,
  output logic        busy,
  output logic        halted
);

  always_comb begin
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    ir_load     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    bus_sel     = BUS_MEM;
    alu_op      = ALU_PASS;
    ac_write_en = 1'b0;
    busy        = (state != S_IDLE) && (state != S_HALT);
    halted      = (state == S_HALT);
    case (state)
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      S_DECODE: begin
        if (opcode == OP_JMP) begin
          pc_load = 1'b1;
          bus_sel = BUS_IR;
        end else if (opcode == OP_JMPZ) begin
          pc_load = zflag;
          bus_sel = BUS_IR;
        end
      end
      S_MEM: begin
        if (opcode == OP_STORE) begin
          mem_wr  = 1'b1;
          bus_sel = BUS_AC;
        end else begin
          mem_rd  = 1'b1;
        end
      end
      S_WB: begin
        ac_write_en = 1'b1;
        case (opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          default: alu_op = ALU_PASS;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_ctrl_seq.sv
// Accumulator control sequencer: 2-4 cycle instructions, stalls on mem_ready low.
// Optional ACC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt and raise illegal_op.
module acc_ctrl_seq
  import acc_pkg::*;
#(
  parameter int reg_width = REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [reg_width-1:0] instr_in,
  input  logic                 mem_ready,
  input  logic                 zflag,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 ir_load,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [1:0]           bus_sel,
  output logic [2:0]           alu_op,
  output logic                 ac_write_en,
  output logic                 busy,
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  output logic                 illegal_op,
`endif
  output logic                 halted
);

  state_t     state;
  logic [3:0] opcode;

  // Operand bits feed the PC/bus directly; the sequencer only needs the opcode.
  logic unused_operand;
  assign unused_operand = ^instr_in[reg_width-5:0];

`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic illegal_now;
  assign illegal_now = (state == S_DECODE) && !op_legal(opcode);
  assign illegal_op  = illegal_q | illegal_now;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      opcode <= '0;
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      if (ir_load)
        opcode <= instr_in[reg_width-1 -: 4];
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state <= S_FETCH;
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
          end
        end
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_HALT:                           state <= S_HALT;
            OP_LOAD, OP_ADD, OP_SUB, OP_STORE: state <= S_MEM;
            default:                           state <= S_FETCH;
          endcase
`ifdef ACC_CTRL_ILLEGAL_TRAP_EN
          if (illegal_now) begin
            state     <= S_HALT;
            illegal_q <= 1'b1;
          end
`endif
        end
        S_MEM: if (mem_ready) state <= (opcode == OP_STORE) ? S_FETCH : S_WB;
        S_WB, S_EXEC: state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
    end
  end

  acc_ctrl_decode u_decode (
    .state       (state),
    .opcode      (opcode),
    .zflag       (zflag),
    .mem_ready   (mem_ready),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .ir_load     (ir_load),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .bus_sel     (bus_sel),
    .alu_op      (alu_op),
    .ac_write_en (ac_write_en),
    .busy        (busy),
    .halted      (halted)
  );

endmodule
